fmt_decoder: RTL and testbench

// Multi-format MSP430 instruction sequencer for the CPU core. Drives register-file, RAM, temp-register and ALU control lines.

---
 rtl/fmt_decoder_pkg.sv | 46 ++++
 rtl/fmt_decoder_load.sv | 103 ++++++++++
 rtl/fmt_decoder.sv | 175 +++++++++++++++++
 tb/tb_fmt_decoder.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmt_decoder_pkg.sv
// Shared encodings for the MSP430 format I / format III instruction sequencer:
// main and load FSM states, opcodes, jump conditions, special registers.
package fmt_decoder_pkg;

    typedef enum logic [3:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_SRC, ST_DST, ST_EXEC, ST_WB, ST_JUMP, ST_ERROR
    } state_e;

    typedef enum logic [2:0] {
        LOAD_IDLE, LOAD_INDEXPC, LOAD_INDEXREG, LOAD_INDIRECT, LOAD_INCREMENT, LOAD_DONE
    } load_e;

    localparam logic [3:0] OP_MOV = 4'h4;
    localparam logic [3:0] OP_ADD = 4'h5;
    localparam logic [3:0] OP_CMP = 4'h9;
    localparam logic [3:0] OP_BIT = 4'hB;

    localparam logic [2:0] JC_JNZ = 3'd0;
    localparam logic [2:0] JC_JZ  = 3'd1;
    localparam logic [2:0] JC_JNC = 3'd2;
    localparam logic [2:0] JC_JC  = 3'd3;
    localparam logic [2:0] JC_JN  = 3'd4;
    localparam logic [2:0] JC_JGE = 3'd5;
    localparam logic [2:0] JC_JL  = 3'd6;

    localparam logic [3:0] REG_PC = 4'd0;
    localparam logic [3:0] REG_SR = 4'd2;
    localparam logic [3:0] REG_CG = 4'd3;

    // flags ordered {V,N,Z,C}
    function automatic logic jump_taken(input logic [2:0] cond, input logic [3:0] flags);
        logic v, n, z, c;
        {v, n, z, c} = flags;
        case (cond)
            JC_JNZ:  return !z;
            JC_JZ:   return z;
            JC_JNC:  return !c;
            JC_JC:   return c;
            JC_JN:   return n;
            JC_JGE:  return !(n ^ v);
            JC_JL:   return n ^ v;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/fmt_decoder_load.sv
// Addressing-mode operand load FSM, time-shared between the source and
// destination phases of the instruction sequencer.
module fmt_decoder_load
    import fmt_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       arst_n,
    input  logic       start,
    input  logic [3:0] reg_in,
    input  logic [1:0] as_in,
    input  logic       cg_en,
    input  logic       addr_only,
    input  logic       mem_ready,
    output logic [3:0] regno,
    output logic [1:0] as_out,
    output logic       reg_inc,
    output logic       ram_read,
    output logic       done
);

    load_e state_q, state_d;
    logic  is_const;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state_q <= LOAD_IDLE;
        else         state_q <= state_d;
    end

    // R3 (any mode) and R2 with As[1] come from the constant generator
    always_comb begin
        is_const = cg_en && ((reg_in == REG_CG) || ((reg_in == REG_SR) && as_in[1]));
    end

    always_comb begin
        state_d  = state_q;
        regno    = '0;
        as_out   = '0;
        reg_inc  = 1'b0;
        ram_read = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            LOAD_IDLE: begin
                if (start) begin
                    regno  = reg_in;
                    as_out = as_in;
                    if (as_in == 2'b00 || is_const) done    = 1'b1;
                    else if (as_in == 2'b01)        state_d = LOAD_INDEXPC;
                    else                            state_d = LOAD_INDIRECT;
                end
            end
            LOAD_INDEXPC: begin
                regno   = REG_PC;
                reg_inc = 1'b1;
                state_d = LOAD_INDEXREG;
            end
            LOAD_INDEXREG: begin
                regno    = reg_in;
                as_out   = 2'b01;
                ram_read = 1'b1;
                if (mem_ready) begin
                    // a MOV destination only needs the address, not the old value
                    if (addr_only) begin
                        done    = 1'b1;
                        state_d = LOAD_IDLE;
                    end else begin
                        state_d = LOAD_DONE;
                    end
                end
            end
            LOAD_DONE: begin
                regno    = reg_in;
                as_out   = 2'b01;
                ram_read = 1'b1;
                if (mem_ready) begin
                    done    = 1'b1;
                    state_d = LOAD_IDLE;
                end
            end
            LOAD_INDIRECT: begin
                regno    = reg_in;
                as_out   = as_in;
                ram_read = 1'b1;
                if (mem_ready) begin
                    if (as_in[0]) begin
                        state_d = LOAD_INCREMENT;
                    end else begin
                        done    = 1'b1;
                        state_d = LOAD_IDLE;
                    end
                end
            end
            LOAD_INCREMENT: begin
                regno   = reg_in;
                as_out  = as_in;
                reg_inc = 1'b1;
                done    = 1'b1;
                state_d = LOAD_IDLE;
            end
            default: state_d = LOAD_IDLE;
        endcase
    end

endmodule

// File: rtl/fmt_decoder.sv
// MSP430 format I / format III instruction sequencer driving register file,
// RAM, temp registers and ALU control lines, with memory-ready stalls.
module fmt_decoder
    import fmt_decoder_pkg::*;
#(
    parameter bit EN_ALU    = 1'b1,
    parameter bit EN_JUMP   = 1'b1,
    parameter bit EN_DSTIDX = 1'b1,
    parameter bit TRAP_ILL  = 1'b1
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic [15:0] data_in,
    input  logic [3:0]  flags_in,
    input  logic        mem_ready,
    output logic        bytemode,
    output logic [1:0]  As,
    output logic [3:0]  regno,
    output logic        reg_store,
    output logic        reg_inc,
    output logic        ram_store,
    output logic        ram_read,
    output logic        s_store,
    output logic        s_read,
    output logic        d_store,
    output logic        d_read,
    output logic [3:0]  alu_op,
    output logic        alu_en,
    output logic        sr_store,
    output logic        pc_offset_add,
    output logic        illegal
);

    state_e      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic        is_mov, dst_idx;
    logic        dec_jump, dec_fmt1, dec_illegal;
    logic        ld_start, ld_cg, ld_addr_only, ld_reg_inc, ld_ram_read, ld_done;
    logic [3:0]  ld_reg, ld_regno;
    logic [1:0]  ld_as, ld_as_out;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        is_mov      = instr_q[15:12] == OP_MOV;
        dst_idx     = instr_q[7];
        dec_jump    = EN_JUMP && (data_in[15:13] == 3'b001);
        dec_fmt1    = (data_in[15:12] == OP_MOV) || (EN_ALU && (data_in[15:12] >= OP_ADD));
        dec_illegal = !(dec_jump || dec_fmt1) || (dec_fmt1 && data_in[7] && !EN_DSTIDX);
    end

    // Load FSM operands depend only on registered state, never on its own outputs
    always_comb begin
        ld_start     = (state_q == ST_SRC) || (state_q == ST_DST);
        ld_cg        = state_q == ST_SRC;
        ld_addr_only = (state_q == ST_DST) && is_mov;
        if (state_q == ST_DST) begin
            ld_reg = instr_q[3:0];
            ld_as  = {1'b0, instr_q[7]};
        end else begin
            ld_reg = instr_q[11:8];
            ld_as  = instr_q[5:4];
        end
    end

    fmt_decoder_load u_load (
        .clk       (clk),
        .arst_n    (arst_n),
        .start     (ld_start),
        .reg_in    (ld_reg),
        .as_in     (ld_as),
        .cg_en     (ld_cg),
        .addr_only (ld_addr_only),
        .mem_ready (mem_ready),
        .regno     (ld_regno),
        .as_out    (ld_as_out),
        .reg_inc   (ld_reg_inc),
        .ram_read  (ld_ram_read),
        .done      (ld_done)
    );

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        bytemode      = 1'b0;
        As            = '0;
        regno         = '0;
        reg_store     = 1'b0;
        reg_inc       = 1'b0;
        ram_store     = 1'b0;
        ram_read      = 1'b0;
        s_store       = 1'b0;
        s_read        = 1'b0;
        d_store       = 1'b0;
        d_read        = 1'b0;
        alu_op        = '0;
        alu_en        = 1'b0;
        sr_store      = 1'b0;
        pc_offset_add = 1'b0;
        illegal       = 1'b0;
        unique case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                regno   = REG_PC;
                reg_inc = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ram_read = 1'b1;
                if (mem_ready) begin
                    instr_d = data_in;
                    if (dec_illegal) begin
                        illegal = 1'b1;
                        state_d = TRAP_ILL ? ST_ERROR : ST_FETCH;
                    end else if (dec_jump) begin
                        state_d = ST_JUMP;
                    end else begin
                        state_d = ST_SRC;
                    end
                end
            end
            ST_SRC, ST_DST: begin
                bytemode = instr_q[6];
                regno    = ld_regno;
                As       = ld_as_out;
                reg_inc  = ld_reg_inc;
                ram_read = ld_ram_read;
                if (ld_done) begin
                    if (state_q == ST_SRC) begin
                        s_store = 1'b1;
                        state_d = ST_DST;
                    end else begin
                        d_store = !is_mov;
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                bytemode = instr_q[6];
                alu_en   = 1'b1;
                alu_op   = instr_q[15:12];
                sr_store = !is_mov;
                s_read   = 1'b1;
                d_read   = !is_mov;
                state_d  = (instr_q[15:12] == OP_CMP || instr_q[15:12] == OP_BIT) ? ST_FETCH : ST_WB;
            end
            ST_WB: begin
                bytemode = instr_q[6];
                if (dst_idx) begin
                    ram_store = 1'b1;
                    if (mem_ready) state_d = ST_FETCH;
                end else begin
                    reg_store = 1'b1;
                    regno     = instr_q[3:0];
                    state_d   = ST_FETCH;
                end
            end
            ST_JUMP: begin
                pc_offset_add = jump_taken(instr_q[12:10], flags_in);
                state_d       = ST_FETCH;
            end
            ST_ERROR: illegal = 1'b1;
            default:  state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fmt_decoder.sv
// Directed self-checking bench for fmt_decoder: per-instruction output tallies
// compared against hand-derived cycle counts and control-line activity.
module tb_fmt_decoder;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [15:0] data_in;
    logic [3:0]  flags_in;
    logic        mem_ready;

    logic        bytemode, reg_store, reg_inc, ram_store, ram_read;
    logic        s_store, s_read, d_store, d_read, alu_en, sr_store, pc_offset_add, illegal;
    logic [1:0]  As;
    logic [3:0]  regno, alu_op;

    logic        m_bytemode, m_reg_store, m_reg_inc, m_ram_store, m_ram_read;
    logic        m_s_store, m_s_read, m_d_store, m_d_read, m_alu_en, m_sr_store, m_pc_offset_add, m_illegal;
    logic [1:0]  m_As;
    logic [3:0]  m_regno, m_alu_op;

    int errors = 0;
    int checks = 0;

    int n_reg_store, n_reg_inc, n_ram_store, n_ram_read, n_sr, n_s_store, n_d_store;
    int n_pc_add, n_ill, n_alu, n_byte, n_inc_other, n_rd_r7, n_inc_store;
    logic [3:0] st_regno, inc_regno, alu_seen;

    always #5 clk = ~clk;

    fmt_decoder u_dut (
        .clk(clk), .arst_n(arst_n), .data_in(data_in), .flags_in(flags_in), .mem_ready(mem_ready),
        .bytemode(bytemode), .As(As), .regno(regno), .reg_store(reg_store), .reg_inc(reg_inc),
        .ram_store(ram_store), .ram_read(ram_read), .s_store(s_store), .s_read(s_read),
        .d_store(d_store), .d_read(d_read), .alu_op(alu_op), .alu_en(alu_en), .sr_store(sr_store),
        .pc_offset_add(pc_offset_add), .illegal(illegal)
    );

    fmt_decoder #(.EN_ALU(1'b0), .EN_JUMP(1'b0), .EN_DSTIDX(1'b0), .TRAP_ILL(1'b0)) u_min (
        .clk(clk), .arst_n(arst_n), .data_in(data_in), .flags_in(flags_in), .mem_ready(mem_ready),
        .bytemode(m_bytemode), .As(m_As), .regno(m_regno), .reg_store(m_reg_store), .reg_inc(m_reg_inc),
        .ram_store(m_ram_store), .ram_read(m_ram_read), .s_store(m_s_store), .s_read(m_s_read),
        .d_store(m_d_store), .d_read(m_d_read), .alu_op(m_alu_op), .alu_en(m_alu_en), .sr_store(m_sr_store),
        .pc_offset_add(m_pc_offset_add), .illegal(m_illegal)
    );

    // {bytemode, As, regno, reg_store, reg_inc, ram_store, ram_read,
    //  s_store, s_read, d_store, d_read, alu_op, alu_en, sr_store, pc_offset_add, illegal}
    function automatic logic [22:0] outs();
        return {bytemode, As, regno, reg_store, reg_inc, ram_store, ram_read,
                s_store, s_read, d_store, d_read, alu_op, alu_en, sr_store, pc_offset_add, illegal};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst_n    = 1'b0;
        data_in   = '0;
        flags_in  = '0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        #1;
    endtask

    // Runs a fixed number of cycles starting in FETCH, tallying control activity.
    task automatic run_instr(input logic [15:0] word, input logic [3:0] flags,
                             input int cycles, input int store_stall);
        int stall;
        stall = store_stall;
        n_reg_store = 0; n_reg_inc = 0; n_ram_store = 0; n_ram_read = 0; n_sr = 0;
        n_s_store = 0; n_d_store = 0; n_pc_add = 0; n_ill = 0; n_alu = 0; n_byte = 0;
        n_inc_other = 0; n_rd_r7 = 0; n_inc_store = 0;
        st_regno = '0; inc_regno = '0; alu_seen = '0;
        data_in  = word;
        flags_in = flags;
        for (int i = 0; i < cycles; i++) begin
            mem_ready = 1'b1;
            #1;
            if (ram_store && stall > 0) begin
                mem_ready = 1'b0;
                stall--;
            end
            #1;
            if (reg_store) begin n_reg_store++; st_regno = regno; end
            if (reg_inc) begin
                n_reg_inc++;
                if (regno != 4'd0) begin n_inc_other++; inc_regno = regno; end
            end
            if (reg_inc && reg_store) n_inc_store++;
            if (ram_store) n_ram_store++;
            if (ram_read) begin
                n_ram_read++;
                if (regno == 4'd7 && As == 2'b01) n_rd_r7++;
            end
            if (sr_store) n_sr++;
            if (s_store) n_s_store++;
            if (d_store) n_d_store++;
            if (pc_offset_add) n_pc_add++;
            if (illegal) n_ill++;
            if (bytemode) n_byte++;
            if (alu_en) begin n_alu++; alu_seen = alu_op; end
            tick();
        end
        mem_ready = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (outs() !== 23'h0) begin
            errors++; $display("FAIL reset_outputs: got %h want 000000", outs());
        end
        tick();
        checks++;
        if ({reg_inc, regno, ram_read} !== {1'b1, 4'd0, 1'b0}) begin
            errors++; $display("FAIL reset_first_fetch: got inc=%b reg=%0d rd=%b want 1 0 0", reg_inc, regno, ram_read);
        end
    endtask

    task automatic test_mov();
        run_instr(16'h4506, 4'h0, 6, 0);
        checks++;
        if ({reg_inc, regno, ram_read} !== {1'b1, 4'd0, 1'b0}) begin
            errors++; $display("FAIL mov_next_fetch: got inc=%b reg=%0d rd=%b", reg_inc, regno, ram_read);
        end
        checks++;
        if (n_reg_store != 1 || st_regno !== 4'd6) begin
            errors++; $display("FAIL mov_reg_store: got %0d stores reg %0d want 1 reg 6", n_reg_store, st_regno);
        end
        checks++;
        if (n_sr != 0 || n_d_store != 0 || n_s_store != 1) begin
            errors++; $display("FAIL mov_ctrl: got sr=%0d d_store=%0d s_store=%0d want 0 0 1", n_sr, n_d_store, n_s_store);
        end
        checks++;
        if (n_alu != 1 || alu_seen !== 4'h4) begin
            errors++; $display("FAIL mov_alu: got %0d cycles op %h want 1 op 4", n_alu, alu_seen);
        end
    endtask

    task automatic test_add_rmw();
        run_instr(16'h54B7, 4'h0, 11, 0);
        checks++;
        if ({reg_inc, regno, ram_read} !== {1'b1, 4'd0, 1'b0}) begin
            errors++; $display("FAIL add_next_fetch: got inc=%b reg=%0d rd=%b", reg_inc, regno, ram_read);
        end
        checks++;
        if (n_ram_store != 1 || n_reg_store != 0) begin
            errors++; $display("FAIL add_stores: got ram=%0d reg=%0d want 1 0", n_ram_store, n_reg_store);
        end
        checks++;
        if (n_sr != 1 || alu_seen !== 4'h5) begin
            errors++; $display("FAIL add_alu: got sr=%0d op=%h want 1 5", n_sr, alu_seen);
        end
        checks++;
        if (n_reg_inc != 3 || n_inc_other != 1 || inc_regno !== 4'd4) begin
            errors++; $display("FAIL add_increment: got inc=%0d other=%0d reg=%0d want 3 1 4", n_reg_inc, n_inc_other, inc_regno);
        end
        checks++;
        if (n_ram_read != 4 || n_rd_r7 != 2) begin
            errors++; $display("FAIL add_reads: got %0d (r7 %0d) want 4 (2)", n_ram_read, n_rd_r7);
        end
        checks++;
        if (n_d_store != 1 || n_s_store != 1 || n_inc_store != 0) begin
            errors++; $display("FAIL add_temps: got d=%0d s=%0d inc&store=%0d want 1 1 0", n_d_store, n_s_store, n_inc_store);
        end
    endtask

    task automatic test_cmp_cg();
        run_instr(16'h9309, 4'h0, 5, 0);
        checks++;
        if ({reg_inc, regno, ram_read} !== {1'b1, 4'd0, 1'b0}) begin
            errors++; $display("FAIL cmp_next_fetch: got inc=%b reg=%0d rd=%b", reg_inc, regno, ram_read);
        end
        checks++;
        if (n_sr != 1 || n_reg_store != 0 || n_ram_store != 0) begin
            errors++; $display("FAIL cmp_ctrl: got sr=%0d reg=%0d ram=%0d want 1 0 0", n_sr, n_reg_store, n_ram_store);
        end
        checks++;
        if (n_ram_read != 1 || n_reg_inc != 1 || n_d_store != 1) begin
            errors++; $display("FAIL cmp_no_load: got rd=%0d inc=%0d d=%0d want 1 1 1", n_ram_read, n_reg_inc, n_d_store);
        end
    endtask

    task automatic test_jump();
        logic [15:0] words [8] = '{16'h27FE, 16'h27FE, 16'h3400, 16'h3400, 16'h3800, 16'h2C00, 16'h3C00, 16'h2000};
        logic [3:0]  flags [8] = '{4'b0010, 4'b0000, 4'b1100, 4'b0100, 4'b0100, 4'b1110, 4'b0000, 4'b0010};
        int          taken [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
        for (int j = 0; j < 8; j++) begin
            run_instr(words[j], flags[j], 3, 0);
            checks++;
            if (n_pc_add != taken[j] || n_ill != 0) begin
                errors++; $display("FAIL jump_%0d: %h flags %b got add=%0d want %0d", j, words[j], flags[j], n_pc_add, taken[j]);
            end
            checks++;
            if ({reg_inc, regno, ram_read} !== {1'b1, 4'd0, 1'b0}) begin
                errors++; $display("FAIL jump_%0d_fetch: got inc=%b reg=%0d rd=%b", j, reg_inc, regno, ram_read);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_instr(16'h4546, 4'h0, 6, 0);
        checks++;
        if (n_byte != 4 || st_regno !== 4'd6) begin
            errors++; $display("FAIL b2b_byte_mov: got byte=%0d reg=%0d want 4 6", n_byte, st_regno);
        end
        run_instr(16'h4506, 4'h0, 6, 0);
        checks++;
        if (n_byte != 0 || n_reg_store != 1) begin
            errors++; $display("FAIL b2b_word_mov: got byte=%0d stores=%0d want 0 1", n_byte, n_reg_store);
        end
    endtask

    task automatic test_store_stall();
        run_instr(16'h54B7, 4'h0, 13, 2);
        checks++;
        if (n_ram_store != 3) begin
            errors++; $display("FAIL store_stall_hold: got %0d store cycles want 3", n_ram_store);
        end
        checks++;
        if ({reg_inc, regno, ram_read} !== {1'b1, 4'd0, 1'b0}) begin
            errors++; $display("FAIL store_stall_fetch: got inc=%b reg=%0d rd=%b", reg_inc, regno, ram_read);
        end
    endtask

    task automatic test_decode_stall();
        data_in   = 16'h1234;
        mem_ready = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (outs() !== 23'h001000) begin
                errors++; $display("FAIL decode_stall_%0d: got %h want 001000", k, outs());
            end
            tick();
        end
        data_in   = 16'h4506;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (illegal !== 1'b0 || ram_read !== 1'b1) begin
            errors++; $display("FAIL decode_ready: got ill=%b rd=%b want 0 1", illegal, ram_read);
        end
        tick();
        checks++;
        if (s_store !== 1'b1 || regno !== 4'd5) begin
            errors++; $display("FAIL decode_latched: got s_store=%b reg=%0d want 1 5", s_store, regno);
        end
        repeat (4) tick();
        checks++;
        if ({reg_inc, regno, ram_read} !== {1'b1, 4'd0, 1'b0}) begin
            errors++; $display("FAIL decode_stall_fetch: got inc=%b reg=%0d rd=%b", reg_inc, regno, ram_read);
        end
    endtask

    task automatic test_illegal_trap();
        do_reset();
        tick();
        tick();
        data_in   = 16'h1234;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (illegal !== 1'b1) begin
            errors++; $display("FAIL illegal_decode: got %b want 1", illegal);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (outs() !== 23'h000001) begin
                errors++; $display("FAIL illegal_stuck_%0d: got %h want 000001", k, outs());
            end
        end
    endtask

    task automatic test_reset_mid_src();
        do_reset();
        tick();
        data_in   = 16'h54B7;
        mem_ready = 1'b1;
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        checks++;
        if (ram_read !== 1'b1 || regno !== 4'd4) begin
            errors++; $display("FAIL midsrc_indirect: got rd=%b reg=%0d want 1 4", ram_read, regno);
        end
        #1;
        arst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== 23'h0) begin
            errors++; $display("FAIL midsrc_async_clear: got %h want 000000", outs());
        end
        @(negedge clk);
        arst_n = 1'b1;
        #1;
        checks++;
        if (outs() !== 23'h0) begin
            errors++; $display("FAIL midsrc_idle: got %h want 000000", outs());
        end
        tick();
        run_instr(16'h4506, 4'h0, 6, 0);
        checks++;
        if (n_s_store != 1 || n_reg_store != 1 || st_regno !== 4'd6 || n_ram_read != 1) begin
            errors++; $display("FAIL midsrc_restart: got s=%0d st=%0d reg=%0d rd=%0d want 1 1 6 1",
                               n_s_store, n_reg_store, st_regno, n_ram_read);
        end
    endtask

    task automatic test_disabled();
        logic [15:0] bad [4] = '{16'h5406, 16'h2000, 16'h4586, 16'h0000};
        do_reset();
        tick();
        mem_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            data_in = bad[j];
            #1;
            checks++;
            if (m_reg_inc !== 1'b1 || m_regno !== 4'd0 || m_illegal !== 1'b0) begin
                errors++; $display("FAIL min_fetch_%0d: got inc=%b reg=%0d ill=%b want 1 0 0", j, m_reg_inc, m_regno, m_illegal);
            end
            tick();
            checks++;
            if (m_illegal !== 1'b1) begin
                errors++; $display("FAIL min_illegal_%h: got %b want 1", bad[j], m_illegal);
            end
            tick();
        end
        data_in = 16'h4506;
        tick();
        checks++;
        if (m_illegal !== 1'b0) begin
            errors++; $display("FAIL min_mov_legal: got %b want 0", m_illegal);
        end
        tick();
        checks++;
        if (m_s_store !== 1'b1 || m_regno !== 4'd5) begin
            errors++; $display("FAIL min_mov_src: got s_store=%b reg=%0d want 1 5", m_s_store, m_regno);
        end
    endtask

    initial begin
        test_reset();
        test_mov();
        test_add_rmw();
        test_cmp_cg();
        test_jump();
        test_back_to_back();
        test_store_stall();
        test_decode_stall();
        test_illegal_trap();
        test_reset_mid_src();
        test_disabled();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
